// File: rtl/lift_call_queue.sv
// rtl/lift_call_queue.sv - hall-call capture, request encoding and FIFO feeding the lift controller
module lift_call_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    btn,
  input  logic          fsm_done,
  output logic [2:0]    din,
  output logic          q_empty,
  output logic [5:0]    lamp,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LATCHED = 2'd1,
    S_QUEUED  = 2'd2
  } btn_state_t;

  btn_state_t state_q [6];
  btn_state_t state_d [6];

  logic [5:0]    btn_d;
  logic [5:0]    rise;
  logic [5:0]    latched;
  logic [5:0]    push_sel;
  logic [5:0]    pop_hit;
  logic          full;
  logic          push;
  logic          pop;
  logic [2:0]    push_code;
  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_d;
  logic [CW-1:0] count_d;
  logic [2:0]    head_d;

  // bit2 = direction (1 = down); 000 is reserved for "no request"
  function automatic logic [2:0] btn_code(input int unsigned idx);
    case (idx)
      0:       btn_code = 3'b001;
      1:       btn_code = 3'b010;
      2:       btn_code = 3'b011;
      3:       btn_code = 3'b110;
      4:       btn_code = 3'b111;
      5:       btn_code = 3'b100;
      default: btn_code = 3'b000;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    btn_d <= btn;
  end

  assign rise = btn & ~btn_d;
  assign full = (count == CW'(DEPTH));
  assign pop  = fsm_done & ~q_empty;

  always_comb begin
    latched = '0;
    pop_hit = '0;
    for (int i = 0; i < 6; i++) begin
      latched[i] = (state_q[i] == S_LATCHED);
      pop_hit[i] = pop && (din == btn_code(i));
    end
  end

  // lowest-index latched button wins the single push slot
  assign push_sel = full ? 6'b0 : (latched & (~latched + 6'd1));
  assign push     = |push_sel;

  always_comb begin
    push_code = 3'b000;
    for (int i = 0; i < 6; i++) begin
      if (push_sel[i]) push_code = btn_code(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) state_q[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < 6; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE:    if (rise[i]) state_d[i] = S_LATCHED;
        S_LATCHED: if (push_sel[i]) state_d[i] = S_QUEUED;
        S_QUEUED:  if (pop_hit[i]) state_d[i] = rise[i] ? S_LATCHED : S_IDLE;
        default:   state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lamp = '0;
    for (int i = 0; i < 6; i++) begin
      lamp[i] = (state_q[i] != S_IDLE);
    end
  end

  assign rd_ptr_d = pop ? ptr_inc(rd_ptr) : rd_ptr;

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // A push into a FIFO that is (or is about to be) empty must bypass memory to reach din
  always_comb begin
    if (count_d == '0)
      head_d = 3'b000;
    else if (count == CW'(pop))
      head_d = push_code;
    else
      head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      din     <= 3'b000;
      q_empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr  <= rd_ptr_d;
      count   <= count_d;
      din     <= head_d;
      q_empty <= (count_d == '0);
    end
  end

endmodule
